// File: rtl/noc_arb_pkg.sv
// noc_from_arb shared types: FSM states, link byte layout, idle byte.
// Imported by the arbiter top and its round-robin picker.
package noc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    localparam logic       IDLE_CTL  = 1'b1;
    localparam logic [7:0] IDLE_DATA = 8'h00;

    typedef struct packed {
        logic       ctl;
        logic [7:0] data;
    } link_byte_t;

    localparam link_byte_t IDLE_BYTE = '{ctl: IDLE_CTL, data: IDLE_DATA};

endpackage

// File: rtl/noc_from_arb_if.sv
// Source-side byte handshake bundle for noc_from_arb.
// master = response sources, slave = arbiter.
interface noc_from_arb_if #(
    parameter int N = 4
);
    logic [N-1:0]      src_valid;
    logic [N-1:0]      src_ctl;
    logic [N-1:0][7:0] src_data;
    logic [N-1:0]      src_last;
    logic [N-1:0]      src_ready;

    modport master (
        output src_valid, src_ctl, src_data, src_last,
        input  src_ready
    );

    modport slave (
        input  src_valid, src_ctl, src_data, src_last,
        output src_ready
    );
endinterface

// File: rtl/noc_from_arb_rr_pick.sv
// rr_pick: combinational round-robin winner, search from ptr+1 mod N.
// One-hot output, all zero when nothing requests.
module rr_pick
    import noc_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win
);
    always_comb begin
        logic [PW-1:0] idx;
        logic          hit;
        win = '0;
        hit = 1'b0;
        idx = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((32'(ptr) + 32'(k)) % N);
            if (!hit && req[idx]) begin
                win[idx] = 1'b1;
                hit      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/noc_from_arb.sv
// noc_from_arb: packet round-robin arbiter onto the byte-serial from-dev link.
// Optional per-source packet counters with NOC_ARB_STATS_EN.
module noc_from_arb
    import noc_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int GAP = 1,
    parameter int TMO = 15
) (
    input  logic        clk,
    input  logic        reset,
    noc_from_arb_if.slave src,
    output logic        noc_from_dev_ctl,
    output logic [7:0]  noc_from_dev_data,
    output logic        err
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [N-1:0][15:0] pkt_cnt
`endif
);
    localparam int PW = $clog2(N);

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, win;
    logic [PW-1:0] ptr_q, win_idx;
    logic [7:0]    bub_q;
    logic [2:0]    gap_q;
    link_byte_t    link_q, link_d, g_byte;
    logic          g_valid, g_last;
    logic          acc, bubble, tmo_hit, gap_done;

    rr_pick #(.N(N)) u_pick (
        .req (src.src_valid),
        .ptr (ptr_q),
        .win (win)
    );

    // Only the granted source's byte is ever looked at.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_byte  = '0;
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                g_valid     = src.src_valid[i];
                g_last      = src.src_last[i];
                g_byte.ctl  = src.src_ctl[i];
                g_byte.data = src.src_data[i];
            end
            if (win[i]) win_idx = PW'(i);
        end
    end

    assign acc      = (state_q == ST_SEND) && g_valid;
    assign bubble   = (state_q == ST_SEND) && !g_valid;
    assign tmo_hit  = bubble && (bub_q == 8'(TMO - 1));
    assign gap_done = (gap_q == 3'(GAP - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (|src.src_valid) state_d = ST_SEND;
            ST_SEND: if ((acc && g_last) || tmo_hit)
                         state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:  if (gap_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready depends on state and grant only, never on valid.
    always_comb begin
        src.src_ready = '0;
        link_d        = IDLE_BYTE;
        if (state_q == ST_SEND) begin
            src.src_ready = gnt_q;
            if (g_valid) link_d = g_byte;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q  <= '0;
            ptr_q  <= PW'(N - 1);
            bub_q  <= '0;
            gap_q  <= '0;
            link_q <= IDLE_BYTE;
            err    <= 1'b0;
        end else begin
            link_q <= link_d;
            if (state_d != ST_SEND) begin
                gnt_q <= '0;
            end else if (state_q == ST_IDLE) begin
                gnt_q <= win;
                ptr_q <= win_idx;
            end
            bub_q <= (bubble && !tmo_hit) ? bub_q + 8'd1 : 8'd0;
            gap_q <= (state_q == ST_GAP) ? gap_q + 3'd1 : 3'd0;
            if (tmo_hit) err <= 1'b1;
        end
    end

    assign noc_from_dev_ctl  = link_q.ctl;
    assign noc_from_dev_data = link_q.data;

`ifdef NOC_ARB_STATS_EN
    logic [N-1:0][15:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (acc && g_last && gnt_q[i] && cnt_q[i] != 16'hFFFF)
                    cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    assign pkt_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_noc_from_arb.sv
// Bench for noc_from_arb: vector table + scoreboard of link bytes,
// plus hand sequences for reset, latency and counter saturation.
module tb_noc_from_arb;
    import noc_arb_pkg::*;

    localparam int N = 4;
    localparam logic [8:0] IDLE9 = 9'h100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       noc_from_dev_ctl;
    logic [7:0] noc_from_dev_data;
    logic       err;
`ifdef NOC_ARB_STATS_EN
    logic [N-1:0][15:0] pkt_cnt;
`endif

    noc_from_arb_if #(.N(N)) sif ();

    noc_from_arb #(.N(N), .GAP(1), .TMO(15)) dut (
        .clk               (clk),
        .reset             (reset),
        .src               (sif.slave),
        .noc_from_dev_ctl  (noc_from_dev_ctl),
        .noc_from_dev_data (noc_from_dev_data),
        .err               (err)
`ifdef NOC_ARB_STATS_EN
        ,
        .pkt_cnt           (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ctl;
        logic [7:0] data;
        logic       last;
        int         pre;
    } sb_t;

    typedef struct {
        logic [3:0] mask;
        int         npk;
        int         len;
        int         bsrc;
        int         bub;
        logic       exp_err;
        int         exp_tmo;
        int         n_ord;
        int         ord [8];
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    sb_t        strm [N][$];
    logic [8:0] exp_q [$];
    int         ord_q [$];
    int         owner = -1;
    int         tmo_ev = 0;
    bit         gap_chk = 0;
    vec_t       vt [7];

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [8:0] link();
        return {noc_from_dev_ctl, noc_from_dev_data};
    endfunction

    function automatic bit busy();
        for (int s = 0; s < N; s++)
            if (strm[s].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        sif.src_valid = '0;
        sif.src_ctl   = '0;
        sif.src_data  = '0;
        sif.src_last  = '0;
        exp_q.delete();
        ord_q.delete();
        for (int s = 0; s < N; s++) strm[s].delete();
        owner   = -1;
        tmo_ev  = 0;
        gap_chk = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load(logic [3:0] mask, int npk, int len, int bsrc, int bub);
        sb_t b;
        for (int s = 0; s < N; s++) begin
            if (mask[s]) begin
                for (int p = 0; p < npk; p++) begin
                    for (int k = 0; k < len; k++) begin
                        b.ctl  = (k == 0);
                        b.data = {4'(s + 1), 4'(p * 4 + k)};
                        b.last = (k == len - 1);
                        b.pre  = (s == bsrc && p == 0 && k == 1) ? bub : 0;
                        strm[s].push_back(b);
                    end
                end
            end
        end
    endtask

    // Monitor the link, then drive sources for the coming edge.
    task automatic step();
        logic [8:0] got, e;
        @(negedge clk);
        got = link();
        if (got != IDLE9) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL link_extra: got %h expected none", got);
            end else begin
                e = exp_q.pop_front();
                chk("link", 32'(got), 32'(e));
                if (got[8]) ord_q.push_back(int'(got[7:4]) - 1);
            end
        end
        if (gap_chk) begin
            chk("gap_ready", 32'(sif.src_ready), 0);
            gap_chk = 0;
        end
        if (owner >= 0 && !sif.src_ready[owner]) begin
            tmo_ev++;
            owner = -1;
        end
        for (int s = 0; s < N; s++) begin
            sif.src_valid[s] = 1'b0;
            if (strm[s].size() != 0) begin
                if (strm[s][0].pre > 0) begin
                    strm[s][0].pre = strm[s][0].pre - 1;
                end else begin
                    sif.src_valid[s] = 1'b1;
                    sif.src_ctl[s]   = strm[s][0].ctl;
                    sif.src_data[s]  = strm[s][0].data;
                    sif.src_last[s]  = strm[s][0].last;
                    if (sif.src_ready[s]) begin
                        chk("interleave", 32'(owner < 0 || owner == s), 1);
                        exp_q.push_back({strm[s][0].ctl, strm[s][0].data});
                        owner = strm[s][0].last ? -1 : s;
                        if (strm[s][0].last) gap_chk = 1;
                        void'(strm[s].pop_front());
                    end
                end
            end
        end
    endtask

    task automatic drain(string nm);
        int cyc = 0;
        while ((busy() || exp_q.size() != 0) && cyc < 3000) begin
            step();
            cyc++;
        end
        chk({nm, "_drained"}, 32'(cyc < 3000), 1);
        sif.src_valid = '0;
    endtask

    initial begin
        vt[0] = '{4'b0010, 1, 3, 0, 0,  1'b0, 0, 1, '{1, 0, 0, 0, 0, 0, 0, 0}};
        vt[1] = '{4'b1111, 2, 2, 0, 0,  1'b0, 0, 8, '{0, 1, 2, 3, 0, 1, 2, 3}};
        vt[2] = '{4'b1100, 1, 4, 2, 3,  1'b0, 0, 2, '{2, 3, 0, 0, 0, 0, 0, 0}};
        vt[3] = '{4'b0101, 2, 3, 2, 20, 1'b1, 1, 4, '{0, 2, 0, 2, 0, 0, 0, 0}};
        vt[4] = '{4'b1001, 1, 1, 0, 0,  1'b0, 0, 2, '{0, 3, 0, 0, 0, 0, 0, 0}};
        vt[5] = '{4'b0110, 3, 2, 1, 14, 1'b0, 0, 6, '{1, 2, 1, 2, 1, 2, 0, 0}};
        vt[6] = '{4'b1111, 1, 2, 0, 15, 1'b1, 1, 4, '{0, 1, 2, 3, 0, 0, 0, 0}};

        // Reset held with every source requesting.
        sif.src_valid = '1;
        sif.src_ctl   = '1;
        sif.src_last  = '0;
        for (int s = 0; s < N; s++) sif.src_data[s] = 8'h5A;
        repeat (5) begin
            @(negedge clk);
            chk("rst_link", 32'(link()), 32'(IDLE9));
            chk("rst_ready", 32'(sif.src_ready), 0);
            chk("rst_err", 32'(err), 0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("first_gnt", 32'(sif.src_ready), 32'h1);

        // Single packet on src1: latency, contents, gap byte.
        do_reset();
        @(negedge clk);
        sif.src_valid[1] = 1'b1;
        sif.src_ctl[1]   = 1'b1;
        sif.src_data[1]  = 8'hA5;
        sif.src_last[1]  = 1'b0;
        @(negedge clk);
        chk("pkt_link0", 32'(link()), 32'(IDLE9));
        chk("pkt_gnt", 32'(sif.src_ready), 32'h2);
        @(negedge clk);
        chk("pkt_b0", 32'(link()), 32'h1A5);
        sif.src_ctl[1]  = 1'b0;
        sif.src_data[1] = 8'h01;
        @(negedge clk);
        chk("pkt_b1", 32'(link()), 32'h001);
        sif.src_data[1] = 8'h02;
        sif.src_last[1] = 1'b1;
        @(negedge clk);
        chk("pkt_b2", 32'(link()), 32'h002);
        chk("pkt_gap_rdy", 32'(sif.src_ready), 0);
        sif.src_valid[1] = 1'b0;
        @(negedge clk);
        chk("pkt_gap", 32'(link()), 32'(IDLE9));

        // Asynchronous reset in the middle of a packet.
        do_reset();
        @(negedge clk);
        sif.src_valid[1] = 1'b1;
        sif.src_ctl[1]   = 1'b1;
        sif.src_data[1]  = 8'h21;
        sif.src_last[1]  = 1'b0;
        @(negedge clk);
        chk("mid_gnt", 32'(sif.src_ready), 32'h2);
        @(negedge clk);
        chk("mid_b0", 32'(link()), 32'h121);
        sif.src_ctl[1]  = 1'b0;
        sif.src_data[1] = 8'h22;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_link", 32'(link()), 32'(IDLE9));
        chk("async_ready", 32'(sif.src_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        sif.src_valid   = 4'b0011;
        sif.src_ctl     = 4'b0011;
        sif.src_data[0] = 8'h11;
        sif.src_data[1] = 8'h21;
        @(negedge clk);
        chk("post_rst_gnt", 32'(sif.src_ready), 32'h1);

        // Vector table through the scoreboard.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            load(vt[v].mask, vt[v].npk, vt[v].len, vt[v].bsrc, vt[v].bub);
            drain($sformatf("v%0d", v));
            chk($sformatf("v%0d_err", v), 32'(err), 32'(vt[v].exp_err));
            chk($sformatf("v%0d_tmo", v), 32'(tmo_ev), 32'(vt[v].exp_tmo));
            chk($sformatf("v%0d_nord", v), 32'(ord_q.size()), 32'(vt[v].n_ord));
            for (int i = 0; i < vt[v].n_ord && i < ord_q.size(); i++)
                chk($sformatf("v%0d_ord%0d", v, i), 32'(ord_q[i]), 32'(vt[v].ord[i]));
        end

`ifdef NOC_ARB_STATS_EN
        do_reset();
        load(4'b1000, 5, 2, 0, 0);
        drain("stats");
        for (int s = 0; s < N; s++)
            chk($sformatf("cnt%0d", s), 32'(pkt_cnt[s]), (s == 3) ? 32'd5 : 32'd0);
        @(negedge clk);
        dut.cnt_q[3] = 16'hFFFF;
        load(4'b1000, 1, 2, 0, 0);
        drain("stats_sat");
        chk("cnt_sat", 32'(pkt_cnt[3]), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
